// File: rtl/lfsr_prng_gen.sv
// Galois LFSR pseudo-random generator with a bounded "pick" engine that draws
// values in 0..RANGE-1 by rejection sampling, falling back to a folded value.
module lfsr_prng_gen #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] INIT_SEED = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter int unsigned      OUT_W     = 4,
  parameter int unsigned      RANGE     = 9,
  parameter int unsigned      MAX_TRIES = 8,
  parameter int unsigned      NO_REPEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic             use_ext_seed,
  input  logic [WIDTH-1:0] ext_seed,
  input  logic             req,
  output logic [WIDTH-1:0] random,
  output logic [OUT_W-1:0] pick,
  output logic             pick_valid,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [OUT_W:0]   RANGE_EXT = (OUT_W + 1)'(RANGE);
  localparam logic [OUT_W-1:0] RANGE_LO  = OUT_W'(RANGE);
  localparam logic [OUT_W-1:0] RANGE_M1  = OUT_W'(RANGE - 1);
  localparam logic [7:0]       LAST_TRY  = 8'(MAX_TRIES - 1);

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0] pick_q, pick_d;
  logic             vld_q, vld_d;
  logic             last_valid_q, last_valid_d;
  logic [7:0]       tries_q, tries_d;

  logic [WIDTH-1:0] seed_sel;
  logic [OUT_W-1:0] cand;
  logic             reject;
  logic             step;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Zero-extend so RANGE == 2^OUT_W compares correctly (never out of range).
  function automatic logic out_of_range(input logic [OUT_W-1:0] c);
    return ({1'b0, c} >= RANGE_EXT);
  endfunction

  function automatic logic [OUT_W-1:0] fallback(input logic [OUT_W-1:0] c,
                                                input logic [OUT_W-1:0] last,
                                                input logic             lv);
    logic [OUT_W-1:0] f;
    f = out_of_range(c) ? (c - RANGE_LO) : c;
    if ((NO_REPEAT != 0) && lv && (f == last))
      f = (f == RANGE_M1) ? '0 : (f + 1'b1);
    return f;
  endfunction

  always_comb begin
    seed_sel = use_ext_seed ? ext_seed : INIT_SEED;
    if (seed_sel == '0)
      seed_sel = INIT_SEED;

    cand   = lfsr_q[OUT_W-1:0];
    reject = out_of_range(cand) ||
             ((NO_REPEAT != 0) && last_valid_q && (cand == pick_q));
    step   = ((fsm_q == IDLE) && en) || (fsm_q == BUSY);

    lfsr_d       = step ? lfsr_step(lfsr_q) : lfsr_q;
    fsm_d        = fsm_q;
    pick_d       = pick_q;
    vld_d        = 1'b0;
    last_valid_d = last_valid_q;
    tries_d      = tries_q;

    if (seed_load) begin
      lfsr_d  = seed_sel;
      fsm_d   = IDLE;
      tries_d = '0;
    end else if (fsm_q == IDLE) begin
      if (req) begin
        fsm_d   = BUSY;
        tries_d = '0;
      end
    end else if (!reject || (tries_q == LAST_TRY)) begin
      pick_d       = reject ? fallback(cand, pick_q, last_valid_q) : cand;
      vld_d        = 1'b1;
      last_valid_d = 1'b1;
      fsm_d        = IDLE;
      tries_d      = '0;
    end else begin
      tries_d = tries_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= INIT_SEED;
      fsm_q        <= IDLE;
      pick_q       <= '0;
      vld_q        <= 1'b0;
      last_valid_q <= 1'b0;
      tries_q      <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      fsm_q        <= fsm_d;
      pick_q       <= pick_d;
      vld_q        <= vld_d;
      last_valid_q <= last_valid_d;
      tries_q      <= tries_d;
    end
  end

  assign random     = lfsr_q;
  assign pick       = pick_q;
  assign pick_valid = vld_q;
  assign busy       = (fsm_q == BUSY);

endmodule

// File: doc/lfsr_prng_gen.md
LFSR_PRNG_GEN -- requirements
Module: lfsr_prng_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state and random output width, 4..32.
REQ-002 Parameter INIT_SEED, default 16'hACE1: seed loaded at reset, by internal seed load, or in place of a zero seed.
REQ-003 Parameter TAPS, default 16'hB400: Galois feedback mask, WIDTH bits, must give a maximal-length polynomial.
REQ-004 Parameter OUT_W, default 4: width of the bounded pick output.
REQ-005 Parameter RANGE, default 9: pick range 0..RANGE-1; legal only when 2^(OUT_W-1) < RANGE <= 2^OUT_W.
REQ-006 Parameter MAX_TRIES, default 8: rejection samples before fallback, 1..255.
REQ-007 Parameter NO_REPEAT, default 1: when 1, a pick never equals the previous pick.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 en  input  1  free-run step enable, effective while IDLE.
REQ-011 seed_load  input  1  load-seed strobe.
REQ-012 use_ext_seed  input  1  selects ext_seed (1) or INIT_SEED (0) on seed_load.
REQ-013 ext_seed  input  WIDTH  external seed value.
REQ-014 req  input  1  bounded-pick request, sampled only in IDLE.
REQ-015 random  output  WIDTH  current LFSR state, registered.
REQ-016 pick  output  OUT_W  last bounded pick, registered, held until next pick.
REQ-017 pick_valid  output  1  one-cycle pulse, pick updated.
REQ-018 busy  output  1  high while FSM in BUSY.

Function
REQ-019 LFSR step: lsb=1 -> state = (state>>1) XOR TAPS; lsb=0 -> state = state>>1.
REQ-020 State steps each edge when (IDLE and en=1) or FSM in BUSY; otherwise holds.
REQ-021 seed_load=1 (priority over step and FSM): state <= selected seed; selected seed of 0 replaced by INIT_SEED; FSM -> IDLE, try counter cleared, any pending request aborted, no pick_valid.
REQ-022 FSM states IDLE, BUSY; IDLE->BUSY on req=1 and seed_load=0; req while BUSY ignored, not queued.
REQ-023 In BUSY, each edge: candidate = state[OUT_W-1:0] before that edge's step; reject if candidate >= RANGE, or if NO_REPEAT=1, last_valid=1 and candidate == last pick.
REQ-024 Accept: pick <= candidate, pick_valid <= 1 for exactly one cycle, last_valid <= 1, FSM -> IDLE.
REQ-025 Reject: try counter +1; on edge where counter reaches MAX_TRIES-1 and candidate rejected, force fallback: f = candidate>=RANGE ? candidate-RANGE : candidate; if NO_REPEAT and last_valid and f==pick then f = (f==RANGE-1) ? 0 : f+1; accept f per REQ-024.
REQ-026 Latency: req accepted at edge k -> pick_valid high in the cycle after edge k+1+R, R = rejections (R <= MAX_TRIES-1); minimum 2 cycles.
REQ-027 busy = 1 from edge k through the accepting edge; pick_valid and busy never high together.
REQ-028 All arithmetic on OUT_W bits unsigned; RANGE = 2^OUT_W means no range rejection.

Reset
REQ-029 rst=1 at an edge: state/random = INIT_SEED, pick = 0, pick_valid = 0, busy = 0, FSM IDLE, try counter 0, last_valid = 0; rst overrides seed_load, req, en.
REQ-030 Reset mid-BUSY aborts request with no pick_valid.

Verification
REQ-031 Reset, en=1, defaults -> random = ACE1, E270, 7138, 389C, 1C4E, 0E27 on consecutive cycles; en=0 holds value.
REQ-032 Reset, en=0, req one cycle -> busy 1 cycle, then pick=1, pick_valid one-cycle pulse, random = E270; second req -> pick=0.
REQ-033 seed_load with use_ext_seed=1, ext_seed=000F, en=0, then req -> candidate F rejected, next 7 accepted: pick=7, pick_valid 3 cycles after req; random=B407 then stepped.
REQ-034 seed_load with ext_seed=0000 -> random = ACE1; seed_load asserted mid-BUSY -> busy drops next cycle, no pick_valid.
REQ-035 MAX_TRIES=1, seed forcing candidate 0xB -> fallback pick = 2; with last pick 2 and candidate 2 under NO_REPEAT=1 -> pick = 3.
REQ-036 en=1 for 65535 cycles from reset -> random returns to ACE1, never 0000; 10000 picks all < RANGE, no two consecutive equal.
